// File: rtl/conv3_pkg.sv
`default_nettype none
//==============================================================================
// Module      : conv3_pkg
// Description : Shared types and helpers for the conv3 window feeder.
//               fp32_t is the raw IEEE-754 single-precision bit pattern.
//               Pixels are never interpreted, only moved.
//               win_t is one 3x3 neighbourhood in row-major order.
//               cnt_w() gives the counter width needed to index a row or
//               column of a given length.
// Revision    : 1.0 - initial release
//==============================================================================
package conv3_pkg;

   localparam int DATA_W = 32;

   typedef logic [DATA_W-1:0] fp32_t;
   typedef fp32_t [0:8]       win_t;

   localparam fp32_t FP32_ZERO = '0;

   // Width of a counter that runs 0..depth-1. The result is never below 1,
   // so a degenerate depth still yields a legal vector.
   function automatic int cnt_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage : conv3_pkg
`default_nettype wire

// File: rtl/conv3_line_fifo.sv
`default_nettype none
//==============================================================================
// Module      : conv3_line_fifo
// Description : Fixed-length shift line of DEPTH words. Each enabled cycle
//               pushes i_din in at the head. o_tap is the word that entered
//               DEPTH enables ago, which is the same column one image row
//               earlier when DEPTH equals the row width.
//               Storage is not reset. The owner must never expose taps
//               before the line has been refilled.
// Ports       : clk    - clock
//               i_en   - advance the line by one word
//               i_din  - word pushed in at the head
//               o_tap  - oldest word in the line
// Revision    : 1.0 - initial release
//==============================================================================
module conv3_line_fifo
   import conv3_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_din,
   output logic [DATA_W-1:0] o_tap
);

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (i_en) begin
         r_mem[0] <= i_din;
         for (int i = 1; i < DEPTH; i++) begin
            r_mem[i] <= r_mem[i-1];
         end
      end
   end

   assign o_tap = r_mem[DEPTH-1];

endmodule : conv3_line_fifo
`default_nettype wire

// File: rtl/conv3_window_buf.sv
`default_nettype none
//==============================================================================
// Module      : conv3_window_buf
// Description : Raster-stream to 3x3 window converter that feeds the conv3
//               filter stage. Two line buffers keep the previous two rows.
//               A 3x3 register window slides one column per accepted pixel.
//               Only windows that lie fully inside the frame are flagged
//               valid, which gives (IMG_W-2) x (IMG_H-2) windows per frame.
//               The latency is one clock from the accepted pixel. There is
//               no backpressure.
// Ports       : clk        - clock
//               rst_n      - asynchronous active-low reset
//               valid_in   - data_in carries a pixel this cycle
//               data_in    - pixel, raster order
//               data_out   - window, [0] top-left .. [8] bottom-right
//               valid_out  - data_out holds a complete window
//               frame_done - pulse with the frame's last window
//               win_cnt    - windows emitted in the current frame
//                            (present only with CONV3_WIN_CNT_EN)
// Options     : `define CONV3_WIN_CNT_EN to add the win_cnt port/counter.
// Revision    : 1.0 - initial release
//==============================================================================
module conv3_window_buf
   import conv3_pkg::*;
#(
   parameter int IMG_W  = 16,
   parameter int IMG_H  = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out [0:8],
   output logic              valid_out,
   output logic              frame_done
`ifdef CONV3_WIN_CNT_EN
   ,
   output logic [15:0]       win_cnt
`endif
);

   localparam int COL_W = cnt_w(IMG_W);
   localparam int ROW_W = cnt_w(IMG_H);

   localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_H - 1);
   // The first column/row where a full 3x3 neighbourhood exists.
   localparam logic [COL_W-1:0] c_col_win  = COL_W'(2);
   localparam logic [ROW_W-1:0] c_row_win  = ROW_W'(2);

   //---------------------------------------------------------------------------
   // Position counters: the raster coordinate of the next pixel to arrive
   //---------------------------------------------------------------------------
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic             w_col_last;
   logic             w_row_last;
   logic             w_win_ok;

   assign w_col_last = (r_col == c_col_last);
   assign w_row_last = (r_row == c_row_last);
   // A pixel at (r,c) completes an in-frame window only when r>=2 and c>=2.
   // This also masks the columns left over from the previous row and the
   // stale line-buffer contents seen during rows 0-1.
   assign w_win_ok   = (r_row >= c_row_win) && (r_col >= c_col_win);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (valid_in) begin
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Line buffers: lb0 = previous row, lb1 = row before that
   //---------------------------------------------------------------------------
   logic [DATA_W-1:0] w_lb0_tap;
   logic [DATA_W-1:0] w_lb1_tap;

   conv3_line_fifo #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W)
   ) u_lb0 (
      .clk    (clk),
      .i_en   (valid_in),
      .i_din  (data_in),
      .o_tap  (w_lb0_tap)
   );

   conv3_line_fifo #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W)
   ) u_lb1 (
      .clk    (clk),
      .i_en   (valid_in),
      .i_din  (w_lb0_tap),
      .o_tap  (w_lb1_tap)
   );

   //---------------------------------------------------------------------------
   // 3x3 window, index = row*3 + col. Row 0 is the oldest row and col 0 the
   // oldest column. The new right-hand column is {lb1 tap, lb0 tap, pixel}.
   // The window doubles as the data_out register.
   //---------------------------------------------------------------------------
   logic [DATA_W-1:0] r_win [0:8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 9; k++) begin
            r_win[k] <= '0;
         end
      end else if (valid_in) begin
         for (int row = 0; row < 3; row++) begin
            r_win[row*3]     <= r_win[row*3 + 1];
            r_win[row*3 + 1] <= r_win[row*3 + 2];
         end
         r_win[2] <= w_lb1_tap;
         r_win[5] <= w_lb0_tap;
         r_win[8] <= data_in;
      end
   end

   always_comb begin
      for (int k = 0; k < 9; k++) begin
         data_out[k] = r_win[k];
      end
   end

   //---------------------------------------------------------------------------
   // Output strobes. These are forced low on idle cycles so that one accepted
   // pixel gives at most one valid window.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= valid_in && w_win_ok;
         frame_done <= valid_in && w_col_last && w_row_last;
      end
   end

`ifdef CONV3_WIN_CNT_EN
   //---------------------------------------------------------------------------
   // Per-frame window counter. It clears on the frame's first pixel, which
   // never produces a window, so the count read at frame_done stays visible
   // until the next frame starts.
   //---------------------------------------------------------------------------
   logic [15:0] r_win_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win_cnt <= '0;
      end else if (valid_in) begin
         if ((r_row == '0) && (r_col == '0)) begin
            r_win_cnt <= '0;
         end else if (w_win_ok) begin
            r_win_cnt <= r_win_cnt + 16'd1;
         end
      end
   end

   assign win_cnt = r_win_cnt;
`endif

endmodule : conv3_window_buf
`default_nettype wire
